// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// ----------------
// Multi-cycle RV64M multiply / divide / remainder sequencer for the execute stage.
// It uses a shift-add multiplier and a restoring divider, each retiring one bit
// per cycle (64 iterations, or 32 for word ops). Division by zero and signed
// overflow skip the iteration phase and go straight to DONE.
//
// Ports
//   clk, reset              clock and synchronous active-low reset
//   in_valid/in_ready       operation handshake (in_ready only in IDLE)
//   in_op, in_w             opcode (MUL..REMU) and word-variant flag
//   in_rs1, in_rs2, in_rd   source operands and destination register
//   flush                   abort the operation in flight / drop a pending result
//   out_valid/out_ready     result handshake towards writeback
//   out_result, out_rd      result value and its destination register
//   busy                    pipeline stall, high in every state except IDLE
module muldiv_sequencer #(
    parameter int RDW = 5
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2:0]     in_op,
    input  logic           in_w,
    input  logic [63:0]    in_rs1,
    input  logic [63:0]    in_rs2,
    input  logic [RDW-1:0] in_rd,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [63:0]    out_result,
    output logic [RDW-1:0] out_rd,
    output logic           busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             w_q, w_d;
    logic             neg_q, neg_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [63:0]      hi_q, hi_d;     // product upper half / partial remainder
    logic [63:0]      lo_q, lo_d;     // multiplier / dividend-quotient shift register
    logic [63:0]      b_q, b_d;       // multiplicand / divisor magnitude
    logic [63:0]      res_q, res_d;
    logic [RDW-1:0]   rd_q, rd_d;

    logic             is_mulh_s, is_div_s, rem_op_s, sgn1_s, sgn2_s, w_eff_s;
    logic [63:0]      a_ext_s, b_ext_s, mag1_s, mag2_s, special_res_s;
    logic             s1_s, s2_s, div_zero_s, div_ovf_s, special_s, neg_s;
    logic [64:0]      mul_sum_s, div_sh_s, div_sub_s;
    logic             div_ge_s;
    logic [127:0]     prod_s, prodn_s;
    logic [63:0]      quo_s, remv_s, fix_res_s;

    // Operand preparation: width masking, magnitudes, result sign, special cases.
    always_comb begin
        is_mulh_s = (in_op == OP_MULH) || (in_op == OP_MULHSU) || (in_op == OP_MULHU);
        is_div_s  = in_op[2];
        rem_op_s  = in_op[2] && in_op[1];
        sgn1_s    = (in_op == OP_MUL) || (in_op == OP_MULH) || (in_op == OP_MULHSU) ||
                    (in_op == OP_DIV) || (in_op == OP_REM);
        sgn2_s    = (in_op == OP_MUL) || (in_op == OP_MULH) ||
                    (in_op == OP_DIV) || (in_op == OP_REM);
        w_eff_s   = in_w && !is_mulh_s;
        if (w_eff_s) begin
            a_ext_s = sgn1_s ? sext32(in_rs1[31:0]) : {32'd0, in_rs1[31:0]};
            b_ext_s = sgn2_s ? sext32(in_rs2[31:0]) : {32'd0, in_rs2[31:0]};
        end else begin
            a_ext_s = in_rs1;
            b_ext_s = in_rs2;
        end
        s1_s   = sgn1_s && a_ext_s[63];
        s2_s   = sgn2_s && b_ext_s[63];
        mag1_s = s1_s ? (64'd0 - a_ext_s) : a_ext_s;
        mag2_s = s2_s ? (64'd0 - b_ext_s) : b_ext_s;
        div_zero_s = (b_ext_s == 64'd0);
        if (w_eff_s) begin
            div_ovf_s = sgn2_s && (in_rs1[31:0] == 32'h8000_0000) && (in_rs2[31:0] == 32'hFFFF_FFFF);
        end else begin
            div_ovf_s = sgn2_s && (in_rs1 == 64'h8000_0000_0000_0000) && (in_rs2 == 64'hFFFF_FFFF_FFFF_FFFF);
        end
        special_s = is_div_s && (div_zero_s || div_ovf_s);
        // Word results are always sign-extended, even for DIVUW/REMUW.
        if (div_zero_s) begin
            special_res_s = rem_op_s ? (w_eff_s ? sext32(in_rs1[31:0]) : in_rs1) : 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (div_ovf_s) begin
            special_res_s = rem_op_s ? 64'd0 : (w_eff_s ? sext32(in_rs1[31:0]) : in_rs1);
        end else begin
            special_res_s = 64'd0;
        end
        neg_s = rem_op_s ? s1_s : (s1_s ^ s2_s);
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 65'd0);
        div_sh_s  = {hi_q, lo_q[63]};
        div_sub_s = div_sh_s - {1'b0, b_q};
        div_ge_s  = (div_sh_s >= {1'b0, b_q});
    end

    // Final correction: sign, half/quotient/remainder select, word sign-extension.
    always_comb begin
        // After 32 iterations the word product sits 32 bits lower in {hi, lo}.
        prod_s  = w_q ? {64'd0, hi_q[31:0], lo_q[63:32]} : {hi_q, lo_q};
        prodn_s = neg_q ? (128'd0 - prod_s) : prod_s;
        quo_s   = neg_q ? (64'd0 - lo_q) : lo_q;
        remv_s  = neg_q ? (64'd0 - hi_q) : hi_q;
        case (op_q)
            OP_MUL:                      fix_res_s = w_q ? sext32(prodn_s[31:0]) : prodn_s[63:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prodn_s[127:64];
            OP_DIV, OP_DIVU:             fix_res_s = w_q ? sext32(quo_s[31:0]) : quo_s;
            OP_REM, OP_REMU:             fix_res_s = w_q ? sext32(remv_s[31:0]) : remv_s;
            default:                     fix_res_s = 64'd0;
        endcase
    end

    // Next-state and datapath register update; flush overrides everything.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        w_d     = w_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        b_d     = b_q;
        res_d   = res_q;
        rd_d    = rd_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        op_d  = in_op;
                        w_d   = w_eff_s;
                        neg_d = neg_s;
                        rd_d  = in_rd;
                        if (special_s) begin
                            res_d   = special_res_s;
                            state_d = ST_DONE;
                        end else begin
                            cnt_d   = w_eff_s ? 7'd32 : 7'd64;
                            hi_d    = 64'd0;
                            if (is_div_s) begin
                                // Word dividend is pre-shifted so its 32 bits leave lo first.
                                lo_d = w_eff_s ? {mag1_s[31:0], 32'd0} : mag1_s;
                                b_d  = mag2_s;
                            end else begin
                                lo_d = mag2_s;
                                b_d  = mag1_s;
                            end
                            state_d = ST_CALC;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (op_q[2]) begin
                        hi_d = div_ge_s ? div_sub_s[63:0] : div_sh_s[63:0];
                        lo_d = {lo_q[62:0], div_ge_s};
                    end else begin
                        hi_d = mul_sum_s[64:1];
                        lo_d = {mul_sum_s[0], lo_q[63:1]};
                    end
                    cnt_d = cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_d = ST_FIX;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
                ST_FIX: begin
                    res_d   = fix_res_s;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= 3'd0;
            w_q     <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= 7'd0;
            hi_q    <= 64'd0;
            lo_q    <= 64'd0;
            b_q     <= 64'd0;
            res_q   <= 64'd0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            w_q     <= w_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE) && reset;
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = res_q;
    assign out_rd     = rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Testbench for muldiv_sequencer: directed cases plus randomized operations
// checked through a scoreboard queue against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic        in_w = 1'b0;
    logic [63:0] in_rs1 = 64'd0;
    logic [63:0] in_rs2 = 64'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    muldiv_sequencer #(.RDW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_w(in_w), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          lat;
        longint      tcyc;
    } exp_t;

    exp_t   sb_q[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    logic   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic is_word(input logic [2:0] op, input logic w);
        return w && !(op inside {3'd1, 3'd2, 3'd3});
    endfunction

    // Reference model: RV64M semantics with plain SV arithmetic.
    function automatic logic [63:0] model_res(input logic [2:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0] x, y, p;
        longint       sa, sb, sq, sr, smin;
        logic [63:0]  ur, r;
        logic [31:0]  ua, ub, uq, urr;
        logic         wd;
        wd = is_word(op, w);
        r  = 64'd0;
        case (op)
            3'd0: begin
                x = {64'd0, a};
                y = {64'd0, b};
                p = x * y;
                r = wd ? sx(p[31:0]) : p[63:0];
            end
            3'd1, 3'd2, 3'd3: begin
                x = (op != 3'd3) ? {{64{a[63]}}, a} : {64'd0, a};
                y = (op == 3'd1) ? {{64{b[63]}}, b} : {64'd0, b};
                p = x * y;
                r = p[127:64];
            end
            3'd4, 3'd6: begin
                sa   = wd ? longint'(sx(a[31:0])) : longint'(a);
                sb   = wd ? longint'(sx(b[31:0])) : longint'(b);
                smin = wd ? -longint'(64'h8000_0000) : longint'(64'h8000_0000_0000_0000);
                if (sb == 0) begin
                    sq = -1;
                    sr = sa;
                end else if (sa == smin && sb == -1) begin
                    sq = sa;
                    sr = 0;
                end else begin
                    sq = sa / sb;
                    sr = sa % sb;
                end
                ur = (op == 3'd4) ? 64'(sq) : 64'(sr);
                r  = wd ? sx(ur[31:0]) : ur;
            end
            default: begin
                if (wd) begin
                    ua = a[31:0];
                    ub = b[31:0];
                    if (ub == 32'd0) begin
                        uq  = 32'hFFFF_FFFF;
                        urr = ua;
                    end else begin
                        uq  = ua / ub;
                        urr = ua % ub;
                    end
                    r = sx((op == 3'd5) ? uq : urr);
                end else if (b == 64'd0) begin
                    r = (op == 3'd5) ? 64'hFFFF_FFFF_FFFF_FFFF : a;
                end else begin
                    r = (op == 3'd5) ? (a / b) : (a % b);
                end
            end
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
        logic wd, zero, ovf;
        wd   = is_word(op, w);
        zero = wd ? (b[31:0] == 32'd0) : (b == 64'd0);
        ovf  = (op == 3'd4 || op == 3'd6) &&
               (wd ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                   : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF));
        if (op[2] && (zero || ovf)) return 1;
        return wd ? 34 : 66;
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0: v = {$urandom, $urandom};
            1: v = 64'($urandom_range(0, 40));
            2: v = 64'd0 - 64'($urandom_range(1, 40));
            3: v = 64'd0;
            4: v = $urandom_range(0, 1) ? 64'h8000_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
            default: begin
                case ($urandom_range(0, 2))
                    0: v = {$urandom, 32'h8000_0000};
                    1: v = {$urandom, 32'hFFFF_FFFF};
                    default: v = {$urandom, 32'h7FFF_FFFF};
                endcase
            end
        endcase
        return v;
    endfunction

    // Monitor: compare each newly presented result against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb_q.size() == 0) begin
                chk1("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("result", out_result, e.res);
                chk("out_rd", {59'd0, out_rd}, {59'd0, e.rd});
                chki("latency", int'(cyc - e.tcyc), e.lat);
            end
        end
    end

    // Wait (bounded) for in_ready at a falling edge, then present the operation.
    task automatic start_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] rd);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk1("in_ready_timeout", in_ready, 1'b1);
        in_valid = 1'b1;
        in_op    = op;
        in_w     = w;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
    endtask

    task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd,
                         input logic [63:0] exp_res, input int exp_lat, input int hold);
        exp_t e;
        int   n;
        start_op(op, w, a, b, rd);
        out_ready = (hold == 0);
        e.res  = exp_res;
        e.rd   = rd;
        e.lat  = exp_lat;
        e.tcyc = cyc;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_rs1   = {$urandom, $urandom};
        in_rs2   = {$urandom, $urandom};
        in_rd    = 5'($urandom);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk1("out_valid_timeout", out_valid, 1'b1);
            void'(sb_q.pop_front());
        end else begin
            for (int i = 0; i < hold; i++) begin
                chk("hold_result", out_result, exp_res);
                chk1("hold_in_ready", in_ready, 1'b0);
                chk1("hold_busy", busy, 1'b1);
                chk1("hold_valid", out_valid, 1'b1);
                @(negedge clk);
            end
            out_ready = 1'b1;
            @(negedge clk);
            chk1("valid_after_consume", out_valid, 1'b0);
        end
        out_ready = 1'b1;
    endtask

    task automatic rand_op();
        logic [2:0]  op;
        logic        w;
        logic [63:0] a, b;
        op = 3'($urandom_range(0, 7));
        w  = 1'($urandom_range(0, 1));
        a  = rnd64();
        b  = rnd64();
        issue(op, w, a, b, 5'($urandom), model_res(op, w, a, b), model_lat(op, w, a, b),
              $urandom_range(0, 2));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_result", out_result, 64'd0);
        reset = 1'b1;
        #1;
        chk1("release_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Divide / remainder
        issue(3'd4, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66, 0);
        issue(3'd6, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 5'd4, 64'd2, 66, 0);
        issue(3'd7, 1'b0, 64'd20, 64'd3, 5'd5, 64'd2, 66, 0);
        // Divide by zero
        issue(3'd5, 1'b0, 64'd7, 64'd0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        issue(3'd6, 1'b0, 64'd7, 64'd0, 5'd7, 64'd7, 1, 0);
        issue(3'd4, 1'b1, 64'd5, 64'h1_0000_0000, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        // Signed overflow
        issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9,
              64'h8000_0000_0000_0000, 1, 0);
        issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10, 64'd0, 1, 0);
        issue(3'd4, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd11, 64'hFFFF_FFFF_8000_0000, 1, 0);
        // High multiply
        issue(3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12,
              64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        issue(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 64'd0, 66, 0);
        issue(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14,
              64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
        // Word multiply, then backpressure for 5 cycles
        issue(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd21, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0);
        issue(3'd0, 1'b0, 64'd123456789, 64'hFFFF_FFFF_FFFF_FFF9, 5'd22,
              64'd0 - 64'd864197523, 66, 5);

        // Flush at CALC cycle 10
        start_op(3'd4, 1'b0, 64'd1000, 64'd7, 5'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        chk1("calc_busy", busy, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk1("flush_busy", busy, 1'b0);
        chk1("flush_in_ready", in_ready, 1'b1);
        repeat (80) @(negedge clk);
        chk1("flush_no_valid", out_valid, 1'b0);

        // Flush together with in_valid in IDLE: no transfer
        start_op(3'd5, 1'b0, 64'd9, 64'd0, 5'd2);
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        chk1("flush_idle_busy", busy, 1'b0);
        @(negedge clk);
        chk1("flush_idle_valid", out_valid, 1'b0);

        // Flush drops a pending result in DONE
        issue(3'd7, 1'b0, 64'd50, 64'd6, 5'd15, 64'd2, 66, 0);
        start_op(3'd5, 1'b0, 64'd7, 64'd0, 5'd16);
        out_ready = 1'b0;
        sb_q.push_back('{res: 64'hFFFF_FFFF_FFFF_FFFF, rd: 5'd16, lat: 1, tcyc: cyc});
        @(negedge clk);
        in_valid = 1'b0;
        chk1("done_valid", out_valid, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        chk1("flush_done_valid", out_valid, 1'b0);
        chk1("flush_done_busy", busy, 1'b0);

        // Reset mid-CALC
        start_op(3'd1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd17);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk1("midrst_valid", out_valid, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_result", out_result, 64'd0);
        chk("midrst_rd", {59'd0, out_rd}, 64'd0);
        reset = 1'b1;
        #1;
        chk1("midrst_release_ready", in_ready, 1'b1);
        repeat (80) @(negedge clk);
        chk1("midrst_no_valid", out_valid, 1'b0);

        // Randomized operations against the reference model
        for (int k = 0; k < 60; k++) rand_op();

        repeat (3) @(negedge clk);
        chki("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the RV64M multiply/divide/remainder operations in the execute stage. It replaces single-cycle `*`, `/` and `%` with a shift-add multiplier and a restoring divider, each doing one bit per cycle. It accepts one operation at a time through a valid/ready handshake and stalls the pipeline through `busy`. It returns the result and destination register to the writeback path through a second valid/ready handshake.

## Interface
- RDW, 5: width of the destination-register index.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  sequencer can accept; high only in IDLE.
- in_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_w  in  1  word variant (MULW/DIVW/DIVUW/REMW/REMUW); ignored for ops 1-3.
- in_rs1, in_rs2  in  64  source operands.
- in_rd  in  RDW  destination register.
- flush  in  1  abort the operation in flight and drop any pending result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_result  out  64  result value.
- out_rd  out  RDW  destination of the result.
- busy  out  1  high in every state except IDLE; drives the pipeline stall.

## Operation
**States**
- IDLE:
  - Transfer occurs when in_valid && in_ready && !flush.
  - The op, in_w, in_rd, operand magnitudes and result sign are latched.
  - Next state is DONE on a special case, otherwise CALC.
- CALC: one iteration per cycle; the iteration counter K starts at 64, or 32 when in_w is set. After K cycles the state moves to FIX.
- FIX: one cycle. Negates the result when required, selects the high/low half or the quotient/remainder, and applies word sign-extension. Next state is DONE.
- DONE: out_valid=1. Next state is IDLE when out_ready=1.
- flush in any state: next state is IDLE and out_valid drops next cycle. flush overrides a concurrent transfer, iteration or out_ready.

**Operand preparation**
- Word ops use only rs[31:0]: sign-extend for signed ops, zero-extend for unsigned ops.
- Signed operands are converted to magnitudes.
- MULHSU: only rs1 is treated as signed.

**Result sign**
- Product sign = s1 ^ s2.
- Quotient sign = s1 ^ s2.
- Remainder sign = s1.

**Multiply**
- 128-bit accumulator; add the multiplicand when the LSB of the multiplier is 1, shifting right each cycle.
- MUL returns the low 64 bits; MULH/MULHSU/MULHU return the high 64 bits of the signed-corrected 128-bit product.

**Divide**
- Restoring division: shift the remainder left, trial-subtract the divisor, set the quotient bit when the subtraction does not go negative.

**Word results**
- Bits [31:0] of the result, sign-extended to 64 bits. This also applies to DIVUW/REMUW.

**Special cases (DONE directly, no CALC)**
- Divisor is zero (after width masking): quotient = all ones (64-bit, or 32-bit then sign-extended); remainder = dividend.
- Signed overflow (dividend = most negative value, divisor = -1, at the selected width): quotient = dividend; remainder = 0.

**DONE hold**
- out_result and out_rd stay stable while out_valid=1 and out_ready=0.

## Timing
**Reset**
- While reset=0 at an edge: state=IDLE, out_valid=0, out_result=0, out_rd=0, busy=0, counter=0.
- in_ready=0 while reset is low; in_ready=1 in the first cycle after release.
- Reset mid-operation discards all state and no result is produced.

**Latency (from transfer edge T)**
- Normal op: out_valid is first high K+2 cycles after T (CALC K cycles, FIX 1 cycle). That is T+66 for 64-bit ops and T+34 for word ops.
- Special case: out_valid is high in the cycle after T.

**Handshake**
- in_ready = (state==IDLE) && reset.
- A result is consumed at the edge where out_valid && out_ready; the next transfer is accepted no earlier than the following cycle.

**Outputs**
- busy = (state != IDLE).
- Throughput is one operation per K+3 cycles.

## Test plan
- DIV: rs1=20, rs2=-3 -> out_result=0xFFFF_FFFF_FFFF_FFFA, out_valid at T+66. REM with the same operands -> 2. REMU 20%3 -> 2.
- Divide by zero: DIVU rs1=7, rs2=0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1. REM 7/0 -> 7. DIVW rs2=0x1_0000_0000 (low word 0) -> 0xFFFF_FFFF_FFFF_FFFF.
- Overflow: DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000, REM -> 0, both at T+1. DIVW 0x8000_0000 / 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000.
- High multiply: MULHU all-ones x all-ones -> 0xFFFF_FFFF_FFFF_FFFE. MULH -1 x -1 -> 0. MULHSU -1 x all-ones -> 0xFFFF_FFFF_FFFF_FFFF.
- Word multiply: MULW 0x7FFF_FFFF x 2 -> 0xFFFF_FFFF_FFFF_FFFE, out_valid at T+34, out_rd=in_rd.
- Backpressure, flush and reset:
  - out_ready low for 5 cycles -> result stable, in_ready=0, busy=1.
  - flush at CALC cycle 10 -> IDLE next cycle, no out_valid.
  - flush together with in_valid in IDLE -> no transfer.
  - reset low mid-CALC -> all outputs 0.
